// File: rtl/tte_pkg.sv
// -----------------------------------------------------------------------------
// tte_pkg
// Shared definitions for the TTE frame path: descriptor field positions,
// ingress writer state encoding, default frame-length limits, and a helper
// that packs a length descriptor.
// -----------------------------------------------------------------------------
package tte_pkg;

  // Descriptor field positions
  localparam int DESC_ERR_BIT = 15;
  localparam int DESC_PAD_BIT = 14;
  localparam int DESC_LEN_MSB = 10;

  // Frame length limits shared with the downstream processor
  localparam int MAX_FRAME_LEN = 1518;
  localparam int MIN_HDR_LEN   = 14;

  // Ingress writer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    TRUNC = 3'd2,
    PAD   = 3'd3,
    DROP  = 3'd4
  } state_e;

  // Pack {err, padded, 3'b0, len} into a 16-bit descriptor
  function automatic logic [15:0] make_desc(input logic err,
                                            input logic padded,
                                            input logic [10:0] len);
    logic [15:0] d;
    d                  = 16'h0000;
    d[DESC_ERR_BIT]    = err;
    d[DESC_PAD_BIT]    = padded;
    d[DESC_LEN_MSB:0]  = len;
    return d;
  endfunction

endpackage

// File: rtl/tteframe_ingress_writer_stat_cnt.sv
// -----------------------------------------------------------------------------
// tte_stat_cnt
// 16-bit statistics counter that wraps modulo 2^16.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   i_inc      increment by one this cycle
//   o_cnt      current count (registered)
// -----------------------------------------------------------------------------
module tte_stat_cnt (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  // Wrapping count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= 16'd0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tteframe_ingress_writer.sv
// -----------------------------------------------------------------------------
// tteframe_ingress_writer
// Takes byte-wide frames from the port RX MAC, writes the stored bytes into
// the data fifo and then commits one length descriptor per frame into the
// pointer fifo. Admission control, truncation at MAX_LEN and zero-padding up
// to MIN_LEN guarantee every descriptor matches bytes already in the data
// fifo and describes at least a full header.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   rx_dv/rx_data    MAC byte stream, rx_err sampled with rx_dv
//   sfifo_wr/din     data fifo write (registered, one cycle after accept)
//   sfifo_space      data fifo free entries (saturating at 4095)
//   ptr_sfifo_wr/din descriptor write {err, padded, 3'b0, len[10:0]}
//   ptr_sfifo_full   descriptor fifo full, checked at admission only
//   frm_cnt          committed frames
//   drop_cnt         dropped frames
//   err_cnt          committed frames with the err bit set
// -----------------------------------------------------------------------------
module tteframe_ingress_writer
  import tte_pkg::*;
#(
  parameter int MAX_LEN = MAX_FRAME_LEN,
  parameter int MIN_LEN = MIN_HDR_LEN
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        sfifo_wr,
  output logic [7:0]  sfifo_din,
  input  logic [11:0] sfifo_space,
  output logic        ptr_sfifo_wr,
  output logic [15:0] ptr_sfifo_din,
  input  logic        ptr_sfifo_full,
  output logic [15:0] frm_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
  localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
  localparam logic [11:0] MAX_SPACE = 12'(MAX_LEN);

  state_e      r_state;
  logic [10:0] r_len;
  logic        r_err;
  logic        r_sfifo_wr;
  logic [7:0]  r_sfifo_din;
  logic        r_ptr_wr;
  logic [15:0] r_ptr_din;

  state_e      w_state_nxt;
  logic [10:0] w_len_nxt;
  logic        w_err_nxt;
  logic        w_wr;
  logic [7:0]  w_din;
  logic        w_ptr_wr;
  logic [15:0] w_ptr_din;
  logic        w_drop;
  logic        w_admit;

  // Room for a worst-case frame and a free descriptor slot means the
  // descriptor write at frame end can never hit a full fifo.
  assign w_admit = (sfifo_space >= MAX_SPACE) && !ptr_sfifo_full;

  // State register and registered fifo outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_len       <= 11'd0;
      r_err       <= 1'b0;
      r_sfifo_wr  <= 1'b0;
      r_sfifo_din <= 8'h00;
      r_ptr_wr    <= 1'b0;
      r_ptr_din   <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_err       <= w_err_nxt;
      r_sfifo_wr  <= w_wr;
      r_sfifo_din <= w_din;
      r_ptr_wr    <= w_ptr_wr;
      r_ptr_din   <= w_ptr_din;
    end
  end

  // Next-state, length/err tracking and fifo strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_err_nxt   = r_err;
    w_wr        = 1'b0;
    w_din       = 8'h00;
    w_ptr_wr    = 1'b0;
    w_ptr_din   = 16'h0000;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_dv) begin
          if (w_admit) begin
            w_wr        = 1'b1;
            w_din       = rx_data;
            w_len_nxt   = 11'd1;
            w_err_nxt   = rx_err;
            w_state_nxt = RECV;
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = DROP;
          end
        end else begin
          w_len_nxt = 11'd0;
          w_err_nxt = 1'b0;
        end
      end
      RECV, TRUNC: begin
        if (rx_dv) begin
          if ((r_state == RECV) && (r_len < MAX_LEN_L)) begin
            w_wr      = 1'b1;
            w_din     = rx_data;
            w_len_nxt = r_len + 11'd1;
            w_err_nxt = r_err | rx_err;
          end else begin
            // Bytes beyond MAX_LEN are discarded; the frame is flagged.
            w_err_nxt   = 1'b1;
            w_state_nxt = TRUNC;
          end
        end else if (r_len >= MIN_LEN_L) begin
          // Frame end: the last data byte is on the fifo port this cycle,
          // so the descriptor lands one cycle behind it.
          w_ptr_wr    = 1'b1;
          w_ptr_din   = make_desc(r_err, 1'b0, r_len);
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = PAD;
        end
      end
      PAD: begin
        if (r_len < MIN_LEN_L) begin
          w_wr      = 1'b1;
          w_din     = 8'h00;
          w_len_nxt = r_len + 11'd1;
        end else begin
          w_ptr_wr  = 1'b1;
          w_ptr_din = make_desc(1'b1, 1'b1, r_len);
          // A frame that started during padding has lost its head bytes.
          if (rx_dv) begin
            w_drop      = 1'b1;
            w_state_nxt = DROP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (!rx_dv) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  tte_stat_cnt u_frm_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_ptr_wr),
    .o_cnt (frm_cnt)
  );

  tte_stat_cnt u_drop_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_drop),
    .o_cnt (drop_cnt)
  );

  tte_stat_cnt u_err_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_ptr_wr & w_ptr_din[DESC_ERR_BIT]),
    .o_cnt (err_cnt)
  );

  assign sfifo_wr      = r_sfifo_wr;
  assign sfifo_din     = r_sfifo_din;
  assign ptr_sfifo_wr  = r_ptr_wr;
  assign ptr_sfifo_din = r_ptr_din;

endmodule

// File: tb/tb_tteframe_ingress_writer.sv
// -----------------------------------------------------------------------------
// tb_tteframe_ingress_writer
// Self-checking bench: frames are described as byte/err arrays, an abstract
// model derives the bytes and descriptors the fifos must receive, and a
// monitor records what the DUT actually writes (with cycle stamps).
// -----------------------------------------------------------------------------
module tb_tteframe_ingress_writer;

  logic        clk            = 1'b0;
  logic        rstn           = 1'b0;
  logic        rx_dv          = 1'b0;
  logic [7:0]  rx_data        = 8'h00;
  logic        rx_err         = 1'b0;
  logic [11:0] sfifo_space    = 12'd4095;
  logic        ptr_sfifo_full = 1'b0;
  logic        sfifo_wr;
  logic [7:0]  sfifo_din;
  logic        ptr_sfifo_wr;
  logic [15:0] ptr_sfifo_din;
  logic [15:0] frm_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  fb   [0:2047];
  logic        ferr [0:2047];

  logic [7:0]  got_b [$];
  int          got_bc[$];
  logic [15:0] got_d [$];
  int          got_dc[$];

  logic [7:0]  exp_b  [$];
  logic [15:0] exp_d  [$];
  int          exp_end[$];
  int          exp_frm  = 0;
  int          exp_drop = 0;
  int          exp_err  = 0;

  tteframe_ingress_writer dut (
    .clk            (clk),
    .rstn           (rstn),
    .rx_dv          (rx_dv),
    .rx_data        (rx_data),
    .rx_err         (rx_err),
    .sfifo_wr       (sfifo_wr),
    .sfifo_din      (sfifo_din),
    .sfifo_space    (sfifo_space),
    .ptr_sfifo_wr   (ptr_sfifo_wr),
    .ptr_sfifo_din  (ptr_sfifo_din),
    .ptr_sfifo_full (ptr_sfifo_full),
    .frm_cnt        (frm_cnt),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record fifo writes away from the active edge
  always @(negedge clk) begin
    if (sfifo_wr) begin
      got_b.push_back(sfifo_din);
      got_bc.push_back(cyc);
    end
    if (ptr_sfifo_wr) begin
      got_d.push_back(ptr_sfifo_din);
      got_dc.push_back(cyc);
    end
  end

  task automatic clear_all();
    got_b.delete(); got_bc.delete(); got_d.delete(); got_dc.delete();
    exp_b.delete(); exp_d.delete(); exp_end.delete();
  endtask

  // Drive fb/ferr[0..len-1] then `gap` idle cycles; c0 = cycle of byte 0
  task automatic drive_frame(input int len, input logic [11:0] space, input logic full,
                             input int gap, output int c0);
    c0 = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      rx_dv = 1'b1; rx_data = fb[k]; rx_err = ferr[k];
      sfifo_space = space; ptr_sfifo_full = full;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_dv = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
      sfifo_space = 12'd4095; ptr_sfifo_full = 1'b0;
    end
  endtask

  // Reference: what a frame of `len` bytes must produce, from the frame rules
  task automatic model_frame(input int len, input logic [11:0] space, input logic full);
    int n;
    bit e;
    bit p;
    if (space < 12'd1518 || full) begin
      exp_drop++;
      return;
    end
    n = (len > 1518) ? 1518 : len;
    e = (len > 1518);
    p = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_b.push_back(fb[k]);
      if (ferr[k]) e = 1'b1;
    end
    while (n < 14) begin
      exp_b.push_back(8'h00);
      n++; p = 1'b1; e = 1'b1;
    end
    exp_d.push_back({e, p, 3'b000, 11'(n)});
    exp_end.push_back(exp_b.size());
    exp_frm++;
    if (e) exp_err++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din, frm_cnt, drop_cnt, err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got wr=%b din=%h pwr=%b pdin=%h cnt=%0d/%0d/%0d want all zero",
               sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din, frm_cnt, drop_cnt, err_cnt);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({sfifo_wr, ptr_sfifo_wr, frm_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_idle got wr=%b pwr=%b frm=%0d want 0", sfifo_wr, ptr_sfifo_wr, frm_cnt);
    end
  endtask

  // 64-byte incrementing frame; writes one cycle after each byte, descriptor
  // one cycle after the last data write
  task automatic test_basic();
    int c0;
    clear_all();
    for (int k = 0; k < 64; k++) begin fb[k] = 8'(k); ferr[k] = 1'b0; end
    model_frame(64, 12'd4095, 1'b0);
    drive_frame(64, 12'd4095, 1'b0, 4, c0);
    total++;
    if (got_b.size() !== 64) begin
      bad++; $display("FAIL basic_count got=%0d want=64", got_b.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        total++;
        if (got_b[k] !== 8'(k) || got_bc[k] !== c0 + 1 + k) begin
          bad++;
          $display("FAIL basic_byte%0d got=%h@%0d want=%h@%0d", k, got_b[k], got_bc[k], 8'(k), c0 + 1 + k);
          break;
        end
      end
    end
    total++;
    if (got_d.size() !== 1 || got_d[0] !== 16'h0040 || got_dc[0] !== c0 + 65) begin
      bad++; $display("FAIL basic_desc n=%0d got=%h@%0d want=0040@%0d", got_d.size(), got_d[0], got_dc[0], c0 + 65);
    end
    total++;
    if (frm_cnt !== 16'd1 || 16'(exp_frm) !== frm_cnt) begin
      bad++; $display("FAIL basic_frm_cnt got=%0d want=1", frm_cnt);
    end
  endtask

  task automatic test_runt();
    int c0;
    clear_all();
    for (int k = 0; k < 10; k++) begin fb[k] = 8'($urandom_range(1, 255)); ferr[k] = 1'b0; end
    model_frame(10, 12'd4095, 1'b0);
    drive_frame(10, 12'd4095, 1'b0, 20, c0);
    total++;
    if (got_b.size() !== 14 || got_b !== exp_b) begin
      bad++; $display("FAIL runt_bytes got_n=%0d want_n=14 (10 data + 4 zero)", got_b.size());
    end
    total++;
    if (got_d.size() !== 1 || got_d[0] !== 16'hC00E || got_dc[0] !== c0 + 16 || got_bc[13] !== c0 + 15) begin
      bad++; $display("FAIL runt_desc got=%h@%0d lastpad@%0d want=c00e@%0d lastpad@%0d",
                      got_d[0], got_dc[0], got_bc[13], c0 + 16, c0 + 15);
    end
    total++;
    if (err_cnt !== 16'd1 || frm_cnt !== 16'd2) begin
      bad++; $display("FAIL runt_counters got err=%0d frm=%0d want err=1 frm=2", err_cnt, frm_cnt);
    end
  endtask

  task automatic test_trunc();
    int c0;
    clear_all();
    for (int k = 0; k < 1600; k++) begin fb[k] = 8'($urandom); ferr[k] = 1'b0; end
    model_frame(1600, 12'd4095, 1'b0);
    drive_frame(1600, 12'd4095, 1'b0, 4, c0);
    total++;
    if (got_b.size() !== 1518 || got_b !== exp_b) begin
      bad++; $display("FAIL trunc_bytes got_n=%0d want_n=1518", got_b.size());
    end
    total++;
    if (got_d.size() !== 1 || got_d[0] !== 16'h85EE || got_dc[0] !== c0 + 1601) begin
      bad++; $display("FAIL trunc_desc got=%h@%0d want=85ee@%0d", got_d[0], got_dc[0], c0 + 1601);
    end
  endtask

  // Space below MAX_LEN, full pointer fifo, exact-boundary space
  task automatic test_admission();
    int c0;
    logic [11:0] sp [4];
    logic        fl [4];
    sp[0] = 12'd1000; fl[0] = 1'b0;
    sp[1] = 12'd4095; fl[1] = 1'b1;
    sp[2] = 12'd1517; fl[2] = 1'b0;
    sp[3] = 12'd1518; fl[3] = 1'b0;
    clear_all();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 40; k++) begin fb[k] = 8'($urandom); ferr[k] = 1'b0; end
      model_frame(40, sp[f], fl[f]);
      drive_frame(40, sp[f], fl[f], 4, c0);
    end
    total++;
    if (got_b !== exp_b || got_b.size() !== 40) begin
      bad++; $display("FAIL admit_bytes got_n=%0d want_n=40", got_b.size());
    end
    total++;
    if (got_d.size() !== 1 || got_d[0] !== 16'h0028) begin
      bad++; $display("FAIL admit_desc n=%0d got=%h want=0028", got_d.size(), got_d[0]);
    end
    total++;
    if (drop_cnt !== 16'd3 || drop_cnt !== 16'(exp_drop)) begin
      bad++; $display("FAIL admit_drop_cnt got=%0d want=3", drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int c1;
    clear_all();
    for (int k = 0; k < 60; k++) begin fb[k] = 8'($urandom); ferr[k] = 1'b0; end
    model_frame(60, 12'd4095, 1'b0);
    drive_frame(60, 12'd4095, 1'b0, 1, c0);
    ferr[19] = 1'b1;
    model_frame(60, 12'd4095, 1'b0);
    drive_frame(60, 12'd4095, 1'b0, 4, c1);
    total++;
    if (got_b.size() !== 120 || got_b !== exp_b) begin
      bad++; $display("FAIL b2b_bytes got_n=%0d want_n=120", got_b.size());
    end
    total++;
    if (got_d.size() !== 2 || got_d[0] !== 16'h003C || got_d[1] !== 16'h803C) begin
      bad++; $display("FAIL b2b_desc n=%0d got=%h,%h want=003c,803c", got_d.size(), got_d[0], got_d[1]);
    end
    // first descriptor coincides with the second frame's first byte on rx
    total++;
    if (got_dc[0] !== c1 || got_bc[60] !== c1 + 1) begin
      bad++; $display("FAIL b2b_timing got desc@%0d byte60@%0d want desc@%0d byte60@%0d",
                      got_dc[0], got_bc[60], c1, c1 + 1);
    end
  endtask

  // A frame arriving while a runt is still being padded is dropped
  task automatic test_pad_overlap();
    int c0;
    clear_all();
    for (int k = 0; k < 30; k++) begin fb[k] = 8'($urandom); ferr[k] = 1'b0; end
    model_frame(5, 12'd4095, 1'b0);
    drive_frame(5, 12'd4095, 1'b0, 1, c0);
    exp_drop++;
    drive_frame(30, 12'd4095, 1'b0, 3, c0);
    model_frame(16, 12'd4095, 1'b0);
    drive_frame(16, 12'd4095, 1'b0, 4, c0);
    total++;
    if (got_b !== exp_b || got_d !== exp_d) begin
      bad++; $display("FAIL pad_overlap got bytes=%0d descs=%0d want bytes=%0d descs=%0d",
                      got_b.size(), got_d.size(), exp_b.size(), exp_d.size());
    end
    total++;
    if ({frm_cnt, drop_cnt, err_cnt} !== {16'(exp_frm), 16'(exp_drop), 16'(exp_err)}) begin
      bad++; $display("FAIL pad_overlap_cnt got=%0d/%0d/%0d want=%0d/%0d/%0d",
                      frm_cnt, drop_cnt, err_cnt, exp_frm, exp_drop, exp_err);
    end
  endtask

  task automatic test_random();
    int c0;
    int len;
    int nd;
    logic [11:0] sp;
    logic fl;
    clear_all();
    for (int f = 0; f < 24; f++) begin
      if (f == 5) len = 1518;
      else if (f == 11) len = 1519;
      else begin
        case ($urandom_range(0, 3))
          0:       len = $urandom_range(1, 13);
          1:       len = 14;
          default: len = $urandom_range(15, 120);
        endcase
      end
      sp = ($urandom_range(0, 5) == 0) ? 12'($urandom_range(0, 1517)) : 12'($urandom_range(1518, 4095));
      fl = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++) begin
        fb[k] = 8'($urandom); ferr[k] = ($urandom_range(0, 39) == 0);
      end
      model_frame(len, sp, fl);
      drive_frame(len, sp, fl, 18, c0);
    end
    total++;
    if (got_b.size() !== exp_b.size()) begin
      bad++; $display("FAIL rand_byte_count got=%0d want=%0d", got_b.size(), exp_b.size());
    end else begin
      for (int k = 0; k < exp_b.size(); k++) begin
        total++;
        if (got_b[k] !== exp_b[k]) begin
          bad++; $display("FAIL rand_byte%0d got=%h want=%h", k, got_b[k], exp_b[k]);
          break;
        end
      end
    end
    total++;
    if (got_d.size() !== exp_d.size()) begin
      bad++; $display("FAIL rand_desc_count got=%0d want=%0d", got_d.size(), exp_d.size());
    end else begin
      nd = exp_d.size();
      for (int i = 0; i < nd; i++) begin
        total++;
        if (got_d[i] !== exp_d[i]) begin
          bad++; $display("FAIL rand_desc%0d got=%h want=%h", i, got_d[i], exp_d[i]);
        end
        if (got_b.size() == exp_b.size()) begin
          total++;
          if (got_dc[i] <= got_bc[exp_end[i] - 1]) begin
            bad++; $display("FAIL rand_order%0d got desc@%0d lastbyte@%0d want desc after byte",
                            i, got_dc[i], got_bc[exp_end[i] - 1]);
          end
        end
      end
    end
    total++;
    if ({frm_cnt, drop_cnt, err_cnt} !== {16'(exp_frm), 16'(exp_drop), 16'(exp_err)}) begin
      bad++; $display("FAIL rand_counters got=%0d/%0d/%0d want=%0d/%0d/%0d",
                      frm_cnt, drop_cnt, err_cnt, exp_frm, exp_drop, exp_err);
    end
  endtask

  task automatic test_midframe_reset();
    int c0;
    for (int k = 0; k < 30; k++) begin fb[k] = 8'($urandom); ferr[k] = 1'b0; end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      rx_dv = 1'b1; rx_data = fb[k]; rx_err = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0; rx_dv = 1'b0;
    @(negedge clk);
    total++;
    if ({sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din, frm_cnt, drop_cnt, err_cnt} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got wr=%b din=%h pwr=%b pdin=%h cnt=%0d/%0d/%0d want all zero",
               sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din, frm_cnt, drop_cnt, err_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    clear_all();
    exp_frm = 0; exp_drop = 0; exp_err = 0;
    for (int k = 0; k < 20; k++) begin fb[k] = 8'($urandom); ferr[k] = 1'b0; end
    model_frame(20, 12'd4095, 1'b0);
    drive_frame(20, 12'd4095, 1'b0, 4, c0);
    total++;
    if (got_b !== exp_b || got_d.size() !== 1 || got_d[0] !== 16'h0014) begin
      bad++; $display("FAIL midrst_frame got bytes=%0d desc=%h want bytes=20 desc=0014", got_b.size(), got_d[0]);
    end
    total++;
    if ({frm_cnt, drop_cnt, err_cnt} !== {16'd1, 16'd0, 16'd0}) begin
      bad++; $display("FAIL midrst_counters got=%0d/%0d/%0d want=1/0/0", frm_cnt, drop_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_runt();
    test_trunc();
    test_admission();
    test_back_to_back();
    test_pad_overlap();
    test_random();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
